sc_matrix_loader: RTL

//  Write-side sequencer for a bank of SC_Reg_MATRIX-style row registers: produces the shared

---
 rtl/sc_matrix_pkg.sv | 20 ++
 rtl/sc_sync_fall_edge.sv | 45 ++++
 rtl/sc_matrix_loader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sc_matrix_pkg.sv
// rtl/sc_matrix_pkg.sv - shared types and defaults for the matrix loader and row register bank
//
// Purpose : FSM state encoding for sc_matrix_loader and the default row-word width,
//           row count and pacing shared with the SC_Reg_MATRIX row register bank.
// Ports   : none (package).
package sc_matrix_pkg;

  localparam int SC_DATAWIDTH   = 8;
  localparam int SC_NROWS       = 8;
  localparam int SC_PACE_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } sc_state_e;

endpackage

// File: rtl/sc_sync_fall_edge.sv
// rtl/sc_sync_fall_edge.sv - 3-flop synchronizer with falling-edge pulse
//
// Purpose : brings an asynchronous active-low pushbutton into the clock domain and
//           emits a one-cycle pulse when the synchronized level goes 1 -> 0.
// Ports   : clk          in  system clock, rising edge
//           rst          in  asynchronous, active-high reset (all flops -> 0)
//           din          in  raw asynchronous level
//           fall_pulse   out one-cycle pulse on a synchronized falling edge
module sc_sync_fall_edge
  import sc_matrix_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic fall_pulse
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = din;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Flops clear to 0, so a button already held low through reset shows no
  // 1 -> 0 transition; it must be released and pressed again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // s3 holds the older sample, s2 the newer one.
  assign fall_pulse = s3_q & ~s2_q;

endmodule

// File: rtl/sc_matrix_loader.sv
// rtl/sc_matrix_loader.sv - clear/load sequencer for a bank of matrix row registers
//
// Purpose : on a start press, clears every row register, then (mode 1) loads a
//           rotating pattern into rows 0..NROWS-1, one row every PACE_CYCLES+1 cycles.
// Ports   : SC_MATRIX0_CLOCK_50      in  system clock
//           SC_MATRIX0_RESET_InHigh  in  asynchronous, active-high reset
//           start_InLow              in  raw start pushbutton, active low
//           mode_In                  in  0 = clear only, 1 = clear + pattern load
//           seed_InBUS               in  pattern for row 0, sampled in CLEAR
//           clear_OutLow             out shared row clear, active low
//           load_OutLow              out per-row load strobes, active low, one-cold
//           data_OutBUS              out row word, valid with the load strobe
//           busy_Out                 out high whenever the sequencer is not idle
//           done_Out                 out one-cycle pulse as the sequence ends
module sc_matrix_loader
  import sc_matrix_pkg::*;
#(
  parameter int DATAWIDTH   = SC_DATAWIDTH,
  parameter int NROWS       = SC_NROWS,
  parameter int PACE_CYCLES = SC_PACE_CYCLES
) (
  input  logic                 SC_MATRIX0_CLOCK_50,
  input  logic                 SC_MATRIX0_RESET_InHigh,
  input  logic                 start_InLow,
  input  logic                 mode_In,
  input  logic [DATAWIDTH-1:0] seed_InBUS,
  output logic                 clear_OutLow,
  output logic [NROWS-1:0]     load_OutLow,
  output logic [DATAWIDTH-1:0] data_OutBUS,
  output logic                 busy_Out,
  output logic                 done_Out
);

  localparam int RW = $clog2(NROWS);
  localparam int PW = $clog2(PACE_CYCLES + 1);

  localparam logic [RW-1:0] ROW_LAST  = RW'(NROWS - 1);
  localparam logic [PW-1:0] PACE_LAST = PW'(PACE_CYCLES - 1);

  sc_state_e            state_q,   state_d;
  logic [RW-1:0]        row_q,     row_d;
  logic [DATAWIDTH-1:0] pattern_q, pattern_d;
  logic [PW-1:0]        pace_q,    pace_d;

  logic start_pulse;

  sc_sync_fall_edge u_start_sync (
    .clk        (SC_MATRIX0_CLOCK_50),
    .rst        (SC_MATRIX0_RESET_InHigh),
    .din        (start_InLow),
    .fall_pulse (start_pulse)
  );

  // Next-state logic. A start pulse only matters in IDLE, so presses while
  // busy are dropped rather than queued.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    pattern_d = pattern_q;
    pace_d    = pace_q;

    case (state_q)
      ST_IDLE: begin
        if (start_pulse) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        // Seed and mode are captured here; later input changes cannot disturb
        // the running sequence.
        pattern_d = seed_InBUS;
        row_d     = '0;
        pace_d    = '0;
        state_d   = mode_In ? ST_LOAD : ST_DONE;
      end
      ST_LOAD: begin
        pace_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (pace_q == PACE_LAST) begin
          pace_d = '0;
          if (row_q == ROW_LAST) begin
            state_d = ST_DONE;
          end else begin
            row_d     = row_q + RW'(1);
            pattern_d = {pattern_q[DATAWIDTH-2:0], pattern_q[DATAWIDTH-1]};
            state_d   = ST_LOAD;
          end
        end else begin
          pace_d = pace_q + PW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge SC_MATRIX0_CLOCK_50 or posedge SC_MATRIX0_RESET_InHigh) begin
    if (SC_MATRIX0_RESET_InHigh) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      pattern_q <= '0;
      pace_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      pattern_q <= pattern_d;
      pace_q    <= pace_d;
    end
  end

  // Outputs are decoded purely from registered state, so an asynchronous reset
  // drops every strobe in the same cycle. Clear and load live in different
  // states and can therefore never be active together.
  always_comb begin
    clear_OutLow = 1'b1;
    load_OutLow  = '1;
    data_OutBUS  = '0;
    busy_Out     = (state_q != ST_IDLE);
    done_Out     = 1'b0;

    case (state_q)
      ST_CLEAR: clear_OutLow = 1'b0;
      ST_LOAD: begin
        data_OutBUS = pattern_q;
        for (int i = 0; i < NROWS; i++) begin
          if (row_q == RW'(i)) load_OutLow[i] = 1'b0;
        end
      end
      ST_DONE: done_Out = 1'b1;
      default: ;
    endcase
  end

endmodule
